// File: rtl/skew_feeder.sv
// skew_feeder: buffers one NxN matrix from a row-major word stream and replays
// it into N lanes with a diagonal skew (lane j delayed j cycles) for the LU array.
module skew_feeder #(
    parameter int SZ = 8,
    parameter int N  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [SZ-1:0]   in_data,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [N*SZ-1:0] x_out,
    output logic [N-1:0]    x_vld
);
    localparam int NN = N * N;
    localparam int AW = $clog2(NN);
    localparam int CW = $clog2(NN + 1);
    localparam int TW = $clog2(2 * N);
    localparam logic [CW-1:0] LAST_WORD = CW'(NN - 1);
    localparam logic [TW-1:0] LAST_BEAT = TW'(2 * N - 2);

    typedef enum logic [1:0] {LOAD, FULL, STREAM} state_t;

    state_t          r_state, w_stateNext;
    logic [CW-1:0]   r_cnt, w_cntNext;
    logic [TW-1:0]   r_t, w_tNext;
    logic            r_inReady, w_inReadyNext;
    logic            r_busy, w_busyNext;
    logic            r_done, w_doneNext;
    logic [N*SZ-1:0] r_x, w_xNext;
    logic [N-1:0]    r_vld, w_vldNext;
    logic            w_accept;
    logic [TW-1:0]   w_beat;
    logic [N*SZ-1:0] w_laneData;
    logic [N-1:0]    w_laneVld;
    logic [SZ-1:0]   r_mem [NN];

    assign w_accept = (r_state == LOAD) && in_valid && r_inReady;

    // Beat whose values get registered at the coming edge: 0 on the start edge
    assign w_beat = (r_state == STREAM) ? r_t + 1'b1 : '0;

    for (genvar j = 0; j < N; j++) begin : g_lane
        logic [TW-1:0] w_row;
        assign w_row = w_beat - TW'(j);
        assign w_laneVld[j] = (w_beat >= TW'(j)) && (w_row <= TW'(N - 1));
        assign w_laneData[j*SZ +: SZ] = w_laneVld[j] ? r_mem[AW'(w_row * N + j)] : '0;
    end

    always_comb begin
        w_stateNext   = r_state;
        w_cntNext     = r_cnt;
        w_tNext       = r_t;
        w_inReadyNext = 1'b0;
        w_busyNext    = 1'b0;
        w_doneNext    = 1'b0;
        w_xNext       = '0;
        w_vldNext     = '0;
        unique case (r_state)
            LOAD: begin
                w_inReadyNext = 1'b1;
                if (w_accept) begin
                    if (r_cnt == LAST_WORD) begin
                        w_stateNext   = FULL;
                        w_cntNext     = '0;
                        w_inReadyNext = 1'b0;
                    end else begin
                        w_cntNext = r_cnt + 1'b1;
                    end
                end
            end
            FULL: begin
                if (start) begin
                    w_stateNext = STREAM;
                    w_tNext     = '0;
                    w_busyNext  = 1'b1;
                    w_xNext     = w_laneData;
                    w_vldNext   = w_laneVld;
                end
            end
            STREAM: begin
                if (r_t == LAST_BEAT) begin
                    w_stateNext   = LOAD;
                    w_tNext       = '0;
                    w_doneNext    = 1'b1;
                    w_inReadyNext = 1'b1;
                end else begin
                    w_tNext    = w_beat;
                    w_busyNext = 1'b1;
                    w_xNext    = w_laneData;
                    w_vldNext  = w_laneVld;
                end
            end
            default: w_stateNext = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= LOAD;
            r_cnt     <= '0;
            r_t       <= '0;
            r_inReady <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_x       <= '0;
            r_vld     <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_cnt     <= w_cntNext;
            r_t       <= w_tNext;
            r_inReady <= w_inReadyNext;
            r_busy    <= w_busyNext;
            r_done    <= w_doneNext;
            r_x       <= w_xNext;
            r_vld     <= w_vldNext;
        end
    end

    // Matrix storage survives reset; only the handshake state is cleared
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_cnt[AW-1:0]] <= in_data;
        end
    end

    assign in_ready = r_inReady;
    assign busy     = r_busy;
    assign done     = r_done;
    assign x_out    = r_x;
    assign x_vld    = r_vld;
endmodule

// File: tb/tb_skew_feeder.sv
// tb_skew_feeder: directed and randomized loads/streams of skew_feeder, checked
// every cycle against a matrix-level model of the skewed lane schedule.
`timescale 1ns/1ps
module tb_skew_feeder;
    localparam int SZ    = 8;
    localparam int N     = 4;
    localparam int NN    = N * N;
    localparam int BEATS = 2 * N - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [SZ-1:0]   in_data = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            start = 1'b0;
    logic            busy;
    logic            done;
    logic [N*SZ-1:0] x_out;
    logic [N-1:0]    x_vld;

    always #5 clk = ~clk;

    skew_feeder #(.SZ(SZ), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .start(start), .busy(busy), .done(done),
        .x_out(x_out), .x_vld(x_vld)
    );

    int checkCount = 0;
    int passCount  = 0;
    bit checkEn    = 1'b0;

    int            mMode = 0;
    int            mCnt  = 0;
    int            mBeat = 0;
    bit            mReady = 1'b0;
    bit            mDone  = 1'b0;
    logic [SZ-1:0] mWords [NN];

    logic [SZ-1:0]   loadVals [NN];
    logic [N*SZ-1:0] capX [BEATS];
    logic [N-1:0]    capV [BEATS];

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
        checkCount++;
        if (got === want) passCount++;
        else $display("[TB] FAIL %s at %0t: got %0h, required %0h", name, $time, got, want);
    endtask

    // Model: mode 0 loading, 1 holding a full matrix, 2 streaming beat mBeat
    always @(posedge clk) begin
        if (!rst_n) begin
            mMode <= 0; mCnt <= 0; mBeat <= 0; mReady <= 1'b0; mDone <= 1'b0;
        end else begin
            mDone <= 1'b0;
            if (mMode == 0) begin
                mReady <= 1'b1;
                if (in_valid && mReady) begin
                    mWords[mCnt] <= in_data;
                    mCnt <= mCnt + 1;
                    if (mCnt == NN - 1) begin
                        mMode <= 1; mCnt <= 0; mReady <= 1'b0;
                    end
                end
            end else if (mMode == 1) begin
                if (start) begin mMode <= 2; mBeat <= 0; end
            end else if (mBeat == BEATS - 1) begin
                mMode <= 0; mBeat <= 0; mDone <= 1'b1; mReady <= 1'b1;
            end else begin
                mBeat <= mBeat + 1;
            end
        end
    end

    function automatic logic [N*SZ-1:0] modelX();
        logic [N*SZ-1:0] v = '0;
        if (mMode == 2)
            for (int j = 0; j < N; j++)
                if (mBeat - j >= 0 && mBeat - j < N) v[j*SZ +: SZ] = mWords[(mBeat - j) * N + j];
        return v;
    endfunction

    function automatic logic [N-1:0] modelVld();
        logic [N-1:0] v = '0;
        if (mMode == 2)
            for (int j = 0; j < N; j++)
                if (mBeat - j >= 0 && mBeat - j < N) v[j] = 1'b1;
        return v;
    endfunction

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("in_ready", 64'(in_ready), 64'(mReady));
            checkOutput("busy", 64'(busy), 64'(mMode == 2));
            checkOutput("done", 64'(done), 64'(mDone));
            checkOutput("x_vld", 64'(x_vld), 64'(modelVld()));
            checkOutput("x_out", 64'(x_out), 64'(modelX()));
        end
    end

    task automatic applyReset();
        @(negedge clk); rst_n = 1'b0; in_valid = 1'b0; start = 1'b0;
        @(negedge clk); rst_n = 1'b1; checkEn = 1'b1;
    endtask

    // Stream loadVals in; optional random gaps and ignored start pokes
    task automatic applyStimulus(input bit gaps, input bit pokeStart);
        int k = 0;
        int guard = 0;
        bit poked = 1'b0;
        while (k < NN && guard < 300) begin
            @(negedge clk);
            guard++;
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data  = loadVals[k];
            start    = 1'b0;
            if (pokeStart && k == 10 && !poked) begin start = 1'b1; poked = 1'b1; end
            if (in_valid && mReady) begin
                if (pokeStart && k == NN - 1) start = 1'b1;
                k++;
            end
        end
        if (k < NN) checkOutput("load words accepted", 64'(k), 64'(NN));
    endtask

    task automatic streamMatrix(input int idle, input bit junk, input int abortAt, input bit waitDone);
        int n = 0;
        for (int i = 0; i <= idle; i++) begin
            @(negedge clk);
            in_valid = junk;
            in_data  = junk ? 8'hFF : 8'h00;
            start    = (i == idle);
        end
        for (int t = 0; t < BEATS; t++) begin
            @(negedge clk);
            start = 1'b0;
            capX[t] = x_out;
            capV[t] = x_vld;
            if (t == abortAt) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1; in_valid = 1'b0;
                checkOutput("abort x_vld", 64'(x_vld), 64'd0);
                checkOutput("abort busy", 64'(busy), 64'd0);
                @(negedge clk);
                checkOutput("post-abort in_ready", 64'(in_ready), 64'd1);
                checkOutput("post-abort done", 64'(done), 64'd0);
                return;
            end
        end
        if (waitDone) begin
            do begin
                @(negedge clk);
                in_valid = 1'b0;
                n++;
            end while (done !== 1'b1 && n < 10);
            checkOutput("done pulse seen", 64'(done), 64'd1);
            checkOutput("done cycle count", 64'(n), 64'd1);
        end
    endtask

    task automatic checkAscending(input string tag);
        checkOutput({tag, " t0 lane0"}, 64'(capX[0][7:0]), 64'd1);
        checkOutput({tag, " t0 vld"}, 64'(capV[0]), 64'b0001);
        checkOutput({tag, " t1 lane0"}, 64'(capX[1][7:0]), 64'd5);
        checkOutput({tag, " t1 lane1"}, 64'(capX[1][15:8]), 64'd2);
        checkOutput({tag, " t1 vld"}, 64'(capV[1]), 64'b0011);
        checkOutput({tag, " t3 lanes"}, 64'(capX[3]), 64'h04070A0D);
        checkOutput({tag, " t3 vld"}, 64'(capV[3]), 64'b1111);
        checkOutput({tag, " t6 lane3"}, 64'(capX[6][31:24]), 64'd16);
        checkOutput({tag, " t6 vld"}, 64'(capV[6]), 64'b1000);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        applyReset();
        checkOutput("reset in_ready", 64'(in_ready), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset x_vld", 64'(x_vld), 64'd0);
        for (int k = 0; k < NN; k++) loadVals[k] = SZ'(k + 1);

        applyStimulus(1'b0, 1'b0); streamMatrix(0, 1'b0, -1, 1'b1); checkAscending("gapless");
        applyStimulus(1'b1, 1'b0); streamMatrix(2, 1'b0, -1, 1'b1); checkAscending("gaps");
        applyStimulus(1'b1, 1'b1); streamMatrix(3, 1'b0, -1, 1'b1); checkAscending("ignored start");
        applyStimulus(1'b0, 1'b0); streamMatrix(2, 1'b1, -1, 1'b1); checkAscending("junk input");

        applyStimulus(1'b0, 1'b0); streamMatrix(0, 1'b0, 3, 1'b0);
        applyStimulus(1'b0, 1'b0); streamMatrix(0, 1'b0, -1, 1'b1); checkAscending("after abort");

        applyStimulus(1'b0, 1'b0); streamMatrix(0, 1'b0, -1, 1'b0);
        for (int k = 0; k < NN; k++) loadVals[k] = SZ'(NN - k);
        applyStimulus(1'b0, 1'b0); streamMatrix(0, 1'b0, -1, 1'b1);
        checkOutput("b2b t0 lane0", 64'(capX[0][7:0]), 64'd16);
        checkOutput("b2b t3 lanes", 64'(capX[3]), 64'h0D0A0704);

        repeat (8) begin
            for (int k = 0; k < NN; k++) loadVals[k] = SZ'($urandom);
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            streamMatrix($urandom_range(0, 3), 1'($urandom_range(0, 1)), -1, 1'($urandom_range(0, 1)));
        end
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
